// File: rtl/imu_pkg.sv
// imu_pkg: shared register map, command/error codes, state encoding and context type
package imu_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    localparam logic [7:0] CMD_READ = 8'h01;
    localparam logic [7:0] ERR_NONE = 8'h00;
    localparam logic [7:0] ERR_CMD  = 8'h04;
    localparam logic [7:0] ERR_REG  = 8'h08;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] base;
        logic [3:0] len;
    } map_ent_t;

    localparam int N_REGS = 3;
    localparam map_ent_t REG_MAP [N_REGS] = '{
        '{idx: 8'd9,  base: 8'h00, len: 4'd4},
        '{idx: 8'd17, base: 8'h04, len: 4'd3},
        '{idx: 8'd54, base: 8'h08, len: 4'd11}
    };

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] reg_idx;
        logic [7:0] err;
        logic [7:0] base;
        logic [3:0] len;
    } ctx_t;

    // Any error forces len to 0 so the payload reads back as zeros.
    function automatic ctx_t lookup(input logic [7:0] cmd, input logic [7:0] reg_idx);
        ctx_t r;
        r = '{cmd: cmd, reg_idx: reg_idx, err: ERR_CMD, base: 8'h00, len: 4'd0};
        if (cmd == CMD_READ) begin
            r.err = ERR_REG;
            for (int i = 0; i < N_REGS; i++)
                if (REG_MAP[i].idx == reg_idx) begin
                    r.err  = ERR_NONE;
                    r.base = REG_MAP[i].base;
                    r.len  = REG_MAP[i].len;
                end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: synchronizes cs, sck and mosi into the c domain and detects cs/sck edges
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic c,
    input  logic rst_n,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic cs_l,
    output logic cs_fall,
    output logic cs_rise,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s
);

    logic [STAGES-1:0] cs_q, sck_q, mosi_q;
    logic cs_p, sck_p;

    // Equal-depth chains keep mosi aligned with the sck edge that samples it; cs/sck idle high.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= '1;
            sck_q  <= '1;
            mosi_q <= '0;
            cs_p   <= 1'b1;
            sck_p  <= 1'b1;
        end else begin
            cs_q   <= STAGES'({cs_q, cs});
            sck_q  <= STAGES'({sck_q, sck});
            mosi_q <= STAGES'({mosi_q, mosi});
            cs_p   <= cs_q[STAGES-1];
            sck_p  <= sck_q[STAGES-1];
        end
    end

    assign cs_l     = cs_q[STAGES-1];
    assign cs_fall  = cs_p & ~cs_l;
    assign cs_rise  = ~cs_p & cs_l;
    assign sck_rise = ~sck_p & sck_q[STAGES-1];
    assign sck_fall = sck_p & ~sck_q[STAGES-1];
    assign mosi_s   = mosi_q[STAGES-1];

endmodule

// File: rtl/imu_spi_responder.sv
// imu_spi_responder: pipelined SPI mode-3 responder serving a RAM register image, plus sync strobe
module imu_spi_responder
    import imu_pkg::*;
#(
    parameter int SYNC_PERIOD     = 125000,
    parameter int SCK_SYNC_STAGES = 2
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [7:0]  ram_addr,
    input  logic [31:0] ram_q,
    output logic        sync
);

    localparam int SW = $clog2(SYNC_PERIOD + 1);

    logic        cs_l, cs_fall, cs_rise, sck_rise, sck_fall, mosi_s;
    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  cnt, cmd_rx, reg_rx, rx_byte, tx_byte, k;
    logic [6:0]  rx_sh, tx_sh;
    logic [31:0] wbuf;
    logic        f0, f1;
    ctx_t        nx, act;
    logic [SW-1:0] sync_cnt;

    spi_in_sync #(.STAGES(SCK_SYNC_STAGES)) u_sync (
        .c(c), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
        .cs_l(cs_l), .cs_fall(cs_fall), .cs_rise(cs_rise),
        .sck_rise(sck_rise), .sck_fall(sck_fall), .mosi_s(mosi_s)
    );

    assign miso_oe = ~cs_l;
    assign rx_byte = {rx_sh, mosi_s};

    // Response byte for the current byte index: header, buffered payload, then zero fill.
    always_comb begin
        k = cnt - 8'd4;
        tx_byte = cnt == 8'd0 ? 8'h00 :
                  cnt == 8'd1 ? act.cmd :
                  cnt == 8'd2 ? act.reg_idx :
                  cnt == 8'd3 ? act.err :
                  k < {2'b00, act.len, 2'b00} ? wbuf[{k[1:0], 3'b000} +: 8] : 8'h00;
    end

    // Transaction FSM: header capture, miso shifting and RAM word prefetch.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            cnt      <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            cmd_rx   <= '0;
            reg_rx   <= '0;
            miso     <= 1'b0;
            ram_addr <= '0;
            wbuf     <= '0;
            f0       <= 1'b0;
            f1       <= 1'b0;
            nx       <= '0;
            act      <= '0;
        end else begin
            f0 <= 1'b0;
            f1 <= f0;
            if (f1)
                wbuf <= ram_q;
            if (cs_rise) begin
                state <= IDLE;
                miso  <= 1'b0;
                if (cnt >= 8'd2)
                    nx <= lookup(cmd_rx, reg_rx);
            end else if (cs_fall) begin
                state    <= HDR;
                act      <= nx;
                ram_addr <= nx.base;
                f0       <= 1'b1;
                bit_cnt  <= '0;
                cnt      <= '0;
                rx_sh    <= '0;
                miso     <= 1'b0;
            end else if (state != IDLE) begin
                if (sck_fall) begin
                    miso  <= bit_cnt == 3'd0 ? tx_byte[7] : tx_sh[6];
                    tx_sh <= bit_cnt == 3'd0 ? tx_byte[6:0] : {tx_sh[5:0], 1'b0};
                end
                if (sck_rise) begin
                    rx_sh   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (cnt != 8'hff)
                            cnt <= cnt + 8'd1;
                        if (cnt == 8'd0)
                            cmd_rx <= rx_byte;
                        if (cnt == 8'd1)
                            reg_rx <= rx_byte;
                        if (cnt == 8'd3)
                            state <= PAYLOAD;
                        if (cnt >= 8'd7 && cnt[1:0] == 2'd3) begin
                            ram_addr <= act.base + {2'b00, cnt[7:2]};
                            f0       <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Free-running data-ready strobe, one cycle every SYNC_PERIOD cycles.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt <= '0;
            sync     <= 1'b0;
        end else begin
            sync     <= sync_cnt == SW'(SYNC_PERIOD - 1);
            sync_cnt <= sync_cnt == SW'(SYNC_PERIOD - 1) ? '0 : sync_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imu_spi_responder.sv
// tb_imu_spi_responder: directed SPI transactions checked against a scoreboard of expected response bytes
module tb_imu_spi_responder;

    localparam int H = 5;

    logic        c = 1'b0;
    logic        rst_n, cs, sck, mosi;
    logic        miso, miso_oe, sync;
    logic [7:0]  ram_addr;
    logic [31:0] ram_q = '0;
    logic [31:0] mem [256];

    int checks = 0;
    int fails  = 0;
    int txn_id = 0;
    int k = 0;
    bit mon_en = 1'b0;

    logic [7:0] exp_q [$];
    logic [7:0] m_cmd, m_reg, m_err, m_base;
    int         m_len;

    imu_spi_responder #(.SYNC_PERIOD(10), .SCK_SYNC_STAGES(2)) dut (
        .c(c), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .ram_addr(ram_addr), .ram_q(ram_q), .sync(sync)
    );

    always #5 c = ~c;

    always @(posedge c) ram_q <= mem[ram_addr];

    always @(posedge c or negedge rst_n)
        if (!rst_n) k <= 0;
        else k <= k + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge c)
        if (mon_en && rst_n)
            chk("sync", {31'd0, sync}, {31'd0, (k % 10 == 0) && (k != 0)});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_byte(input int b);
        logic [31:0] w;
        int kk;
        kk = b - 4;
        if (b == 0) return 8'h00;
        if (b == 1) return m_cmd;
        if (b == 2) return m_reg;
        if (b == 3) return m_err;
        if (kk >= 4 * m_len) return 8'h00;
        w = mem[8'(m_base + 8'(kk / 4))];
        return w[8 * (kk % 4) +: 8];
    endfunction

    task automatic model_update(input logic [7:0] cmd, input logic [7:0] ri);
        m_cmd = cmd;
        m_reg = ri;
        m_base = 8'h00;
        m_len = 0;
        if (cmd != 8'h01) m_err = 8'h04;
        else if (ri == 8'd9)  begin m_err = 8'h00; m_base = 8'h00; m_len = 4;  end
        else if (ri == 8'd17) begin m_err = 8'h00; m_base = 8'h04; m_len = 3;  end
        else if (ri == 8'd54) begin m_err = 8'h00; m_base = 8'h08; m_len = 11; end
        else m_err = 8'h08;
    endtask

    task automatic model_reset();
        m_cmd = 8'h00; m_reg = 8'h00; m_err = 8'h00; m_base = 8'h00; m_len = 0;
    endtask

    task automatic shift_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge c);
            sck = 1'b0;
            mosi = tx[i];
            repeat (H - 1) @(negedge c);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            repeat (H) @(negedge c);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " miso"}, {31'd0, miso}, 32'd0);
        chk({tag, " miso_oe"}, {31'd0, miso_oe}, 32'd0);
        chk({tag, " ram_addr"}, {24'd0, ram_addr}, 32'd0);
        chk({tag, " sync"}, {31'd0, sync}, 32'd0);
    endtask

    task automatic txn(input logic [7:0] cmd, input logic [7:0] ri, input int nbytes, input int extra);
        logic [7:0] rx, tx;
        txn_id++;
        for (int b = 0; b < nbytes; b++) exp_q.push_back(model_byte(b));
        @(negedge c);
        cs = 1'b0;
        repeat (10) @(negedge c);
        chk($sformatf("t%0d miso_oe active", txn_id), {31'd0, miso_oe}, 32'd1);
        for (int b = 0; b < nbytes; b++) begin
            tx = b == 0 ? cmd : b == 1 ? ri : 8'($urandom);
            shift_bits(tx, 8, rx);
            chk($sformatf("t%0d byte %0d", txn_id, b), {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end
        if (extra > 0) shift_bits(ri, extra, rx);
        repeat (4) @(negedge c);
        cs = 1'b1;
        repeat (12) @(negedge c);
        chk($sformatf("t%0d miso_oe idle", txn_id), {31'd0, miso_oe}, 32'd0);
        if (nbytes >= 2) model_update(cmd, ri);
    endtask

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h01010101;
        rst_n = 1'b0;
        cs = 1'b1;
        sck = 1'b1;
        mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge c);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge c);
        txn(8'h01, 8'd54, 8, 0);
        txn(8'h02, 8'd9, 48, 0);
        txn(8'h01, 8'h63, 8, 0);
        txn(8'h01, 8'd17, 24, 0);
        txn(8'h01, 8'd9, 1, 3);
        txn(8'h01, 8'd9, 24, 0);
        txn(8'h01, 8'd54, 24, 0);
        @(negedge c);
        cs = 1'b0;
        repeat (10) @(negedge c);
        shift_bits(8'h01, 8, rx);
        shift_bits(8'd17, 8, rx);
        repeat (3) @(negedge c);
        rst_n = 1'b0;
        @(negedge c);
        chk_reset_outputs("mid reset");
        cs = 1'b1;
        sck = 1'b1;
        repeat (5) @(negedge c);
        rst_n = 1'b1;
        model_reset();
        repeat (12) @(negedge c);
        txn(8'h01, 8'd54, 8, 0);
        txn(8'h01, 8'd9, 262, 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/imu_spi_responder.md
IMU_SPI_RESPONDER -- requirements
Module: imu_spi_responder

Interface
REQ-001 Parameter SYNC_PERIOD, default 125000, is the number of c cycles between sync pulses (1 kHz at 125 MHz).
REQ-002 Parameter SCK_SYNC_STAGES, default 2, is the synchronizer depth applied to cs, sck and mosi.
REQ-003 c  input  1  is the single system clock (125 MHz); all logic is rising-edge c.
REQ-004 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005 cs  input  1  is the SPI chip select from the external master, active-low and asynchronous to c.
REQ-006 sck  input  1  is the SPI clock, SPI mode 3 (idle high); sck frequency SHALL not exceed c/8.
REQ-007 mosi  input  1  is the master-to-responder data, MSB first.
REQ-008 miso  output  1  is the responder-to-master data, MSB first.
REQ-009 miso_oe  output  1  is high while cs (synchronized) is low.
REQ-010 ram_addr  output  8  is the read address into the 256x32 register-image RAM.
REQ-011 ram_q  input  32  is the RAM read data, valid one c cycle after ram_addr; the word is little-endian, so byte0 = ram_q[7:0].
REQ-012 sync  output  1  is a one-cycle pulse every SYNC_PERIOD cycles that emulates the IMU data-ready strobe.

Function
REQ-013 mosi SHALL be sampled on synchronized sck rising edges; miso SHALL change on synchronized sck falling edges and on cs falling edges.
REQ-014 The protocol is pipelined: while transaction N is in progress, miso carries the response to transaction N-1.
REQ-015 The request header SHALL be byte0 = cmd and byte1 = reg_idx; bytes 2 and 3 are ignored, and subsequent mosi bytes are ignored.
REQ-016 The response SHALL be byte0 = 0x00, byte1 = prev cmd, byte2 = prev reg_idx, byte3 = prev err, followed by payload bytes.
REQ-017 Payload byte k SHALL equal byte (k mod 4) of RAM word (base + k/4) for k < 4*len, and 0x00 thereafter.
REQ-018 The register map SHALL be: reg 9 (base 0x00, len 4), reg 17 (base 0x04, len 3), reg 54 (base 0x08, len 11).
REQ-019 err SHALL be computed per REQ-019a to REQ-019c; when err != 0, len is treated as 0, so the payload is all zeros.
REQ-019a err SHALL be 0x04 (invalid command) when cmd != 0x01.
REQ-019b err SHALL be 0x08 (invalid register) when cmd = 0x01 and reg_idx is not in the map.
REQ-019c err SHALL be 0x00 otherwise.
REQ-020 The state machine SHALL have three states: IDLE -> (cs fall) HDR -> (4th byte complete) PAYLOAD -> (cs rise) IDLE; any state SHALL go to IDLE on cs rise.
REQ-021 On cs fall, the context latched from the previous transaction (cmd, reg_idx, err, base, len) SHALL become the active response context, and RAM word base+0 SHALL be fetched.
REQ-022 The fetch of word base+j+1 SHALL be issued on completion of payload byte 4j+3; the fetched word SHALL be held in a 32-bit buffer.
REQ-023 On cs rise, the new cmd and reg_idx SHALL be latched as the next context only if at least 2 full bytes were received; otherwise the prior next-context is retained.
REQ-024 A partial byte at cs rise SHALL be discarded.
REQ-025 The payload byte counter SHALL be 8 bits and SHALL saturate at 255; it SHALL output 0x00 beyond 4*len and SHALL not wrap.
REQ-026 A cs fall coinciding with a sync pulse SHALL have no interaction; the sync counter is free-running.
REQ-027 The master SHALL provide at least 8 c cycles from cs fall to the first sck fall.

Reset
REQ-028 During rst_n low, the outputs SHALL be: miso=0, miso_oe=0, ram_addr=0, sync=0.
REQ-029 During rst_n low, the state SHALL be IDLE, the synchronizers SHALL hold cs=1 and sck=1, and the sync counter SHALL be 0.
REQ-030 During rst_n low, the next context SHALL be cmd=0x00, reg=0x00, err=0x00, len=0, so the first response after reset is all zeros.
REQ-031 Reset asserted mid-transaction SHALL abort it; the response to that transaction SHALL be lost.

Structure
REQ-032 The register map table (idx, base, len), the command and error code constants and the state encoding SHALL reside in shared package imu_pkg, which imu_reader's consumers also use.
REQ-033 The cs, sck and mosi synchronizers plus the edge detection SHALL be one sub-module, spi_in_sync.

Verification
REQ-034 After reset, read reg 54 -> response bytes 00 00 00 00 then zeros; a second transaction -> 00 01 36 00 followed by the 44 RAM bytes at 0x08..0x12, little-endian.
REQ-035 Transaction with cmd 0x02 and reg 9, then any transaction -> 00 02 09 04 and an all-zero payload.
REQ-036 Request reg 0x63 -> next response 00 01 63 08 and zero payload.
REQ-037 Request reg 17 with a 20-byte payload clock -> 12 RAM bytes, then 8 bytes of 0x00.
REQ-038 cs raised after 1 byte plus 3 bits of a reg 9 request -> the next response still reflects the previous context.
REQ-039 SYNC_PERIOD=10 -> sync high exactly every 10th cycle across back-to-back transactions and a reset pulse that restarts the count.
